// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser.
// ST_CSUM exists only when UART_FRAME_CHECKSUM_EN is defined.
package uart_frame_pkg;

    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD
`ifdef UART_FRAME_CHECKSUM_EN
        , ST_CSUM
`endif
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

endpackage

// File: rtl/uart_frame_parser_if.sv
// RX FIFO pop port plus the payload valid/ready stream of the frame parser.
interface uart_frame_parser_if;
    import uart_frame_pkg::*;

    logic              rx_empty;
    logic [DATA_W-1:0] r_data;
    logic              rd_uart;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    // master = parser side, slave = FIFO/downstream side
    modport master (
        input  rx_empty, r_data, m_ready,
        output rd_uart, m_valid, m_data, m_last
    );
    modport slave (
        output rx_empty, r_data, m_ready,
        input  rd_uart, m_valid, m_data, m_last
    );

endinterface

// File: rtl/uart_frame_parser_timeout.sv
// Inter-byte idle counter; expired_c pulses when the incremented count hits timeout_value.
module uart_frame_timeout #(
    parameter int unsigned n_timeout = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [n_timeout-1:0] timeout_value,
    output logic                 expired_c
);

    logic [n_timeout-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        cnt_inc   = cnt_q + n_timeout'(1);
        cnt_d     = cnt_q;
        expired_c = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d     = cnt_inc;
            // zero timeout_value disables the compare
            expired_c = (timeout_value != '0) && (cnt_inc == timeout_value);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser above the UART RX FIFO: SOF hunt, length check, payload stream, status pulses.
// Define UART_FRAME_CHECKSUM_EN to add the trailing checksum byte and its check.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned                n_data_bits = 8,
    parameter int unsigned                MAX_LEN     = 16,
    parameter logic [n_data_bits-1:0]     SOF         = SOF_DEFAULT,
    parameter int unsigned                n_timeout   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_frame_parser_if.master  bus,
    input  logic [n_timeout-1:0] timeout_value,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [1:0]           err_code
);

    localparam int unsigned W = n_data_bits;

    state_e         state_q, state_d;
    logic [W-1:0]   len_q, len_d;
    logic [W-1:0]   cnt_q, cnt_d;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [W-1:0]   sum_q, sum_d;
`endif
    logic           m_valid_q, m_valid_d;
    logic [W-1:0]   m_data_q, m_data_d;
    logic           m_last_q, m_last_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_err_q, frame_err_d;
    logic [1:0]     err_code_q, err_code_d;

    logic can_take_c, pop_c, in_frame_c, last_c, expired_c;

    // PAYLOAD only pops when the output register is free
    always_comb begin
        can_take_c = (state_q == ST_PAYLOAD) ? (!m_valid_q || bus.m_ready) : 1'b1;
        pop_c      = !reset && !bus.rx_empty && can_take_c;
        in_frame_c = (state_q != ST_IDLE);
        last_c     = (cnt_q == len_q - W'(1));
    end

    uart_frame_timeout #(.n_timeout(n_timeout)) u_timeout (
        .clk           (clk),
        .reset         (reset),
        .clear         (pop_c || !in_frame_c),
        .inc           (in_frame_c && bus.rx_empty),
        .timeout_value (timeout_value),
        .expired_c     (expired_c)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
`ifdef UART_FRAME_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        m_valid_d    = m_valid_q && !bus.m_ready;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q && m_valid_d;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_c && (bus.r_data == SOF)) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (pop_c) begin
                    len_d = bus.r_data;
                    if ((bus.r_data == '0) || (bus.r_data > W'(MAX_LEN))) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        sum_d   = bus.r_data;
`endif
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (pop_c) begin
                    m_valid_d = 1'b1;
                    m_data_d  = bus.r_data;
                    m_last_d  = last_c;
                    cnt_d     = cnt_q + W'(1);
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_d     = sum_q + bus.r_data;
                    if (last_c) state_d = ST_CSUM;
`else
                    if (last_c) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
`endif
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_CSUM: begin
                if (pop_c) begin
                    if (W'(sum_q + bus.r_data) == '0) begin
                        frame_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // expiry only happens with an empty FIFO, so it never collides with a pop
        if (expired_c) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q        <= '0;
`endif
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.rd_uart = pop_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; checksum-specific steps follow UART_FRAME_CHECKSUM_EN.
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] timeout_value;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .n_data_bits (8),
        .MAX_LEN     (16),
        .SOF         (8'hA5),
        .n_timeout   (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .timeout_value (timeout_value),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo [$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.rx_empty = (fifo.size() == 0);
        bus.r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive_fifo();
    endtask

    // One clock: sample the pop strobe before the edge, retire the head byte after it.
    task automatic step();
        logic pop;
        @(negedge clk);
        pop = bus.rd_uart;
        chk("pop_while_empty", 32'(pop && bus.rx_empty), 32'd0);
        @(posedge clk);
        #1;
        if (pop && fifo.size() != 0) fifo.delete(0);
        drive_fifo();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic done, input logic err,
                           input logic [7:0] d, input logic l);
        chk({tag, "_flags"}, {29'd0, bus.m_valid, frame_done, frame_err}, {29'd0, v, done, err});
        if (v) chk({tag, "_data"}, {23'd0, bus.m_data, bus.m_last}, {23'd0, d, l});
    endtask

    // LEN=3, payload 11 22 33; checksum 97 wraps 03+11+22+33+97 to zero
    task automatic good_frame(input string tag);
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33);
`ifdef UART_FRAME_CHECKSUM_EN
        push(8'h97);
`endif
        step(); chk_out({tag, "_sof"}, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_out({tag, "_len"}, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_out({tag, "_b0"},  1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        step(); chk_out({tag, "_b1"},  1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
`ifdef UART_FRAME_CHECKSUM_EN
        step(); chk_out({tag, "_b2"},  1'b1, 1'b0, 1'b0, 8'h33, 1'b1);
        step(); chk_out({tag, "_done"}, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`else
        step(); chk_out({tag, "_b2"},  1'b1, 1'b1, 1'b0, 8'h33, 1'b1);
`endif
        step(); chk_out({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int first;
        int pulses;

        reset         = 1'b1;
        timeout_value = 16'd0;
        bus.m_ready   = 1'b1;
        drive_fifo();
        step();
        push(8'h5A);
        chk("reset_rd_uart", 32'(bus.rd_uart), 32'd0);
        step();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("reset_regs", {21'd0, bus.m_data, bus.m_last, err_code}, 32'd0);
        fifo.delete();
        drive_fifo();
        reset = 1'b0;

        good_frame("good");

`ifdef UART_FRAME_CHECKSUM_EN
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
        step(); step();
        step(); chk_out("badcs_b0", 1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        step(); chk_out("badcs_b1", 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
        step(); chk_out("badcs_b2", 1'b1, 1'b0, 1'b0, 8'h33, 1'b1);
        step(); chk_out("badcs_err", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("badcs_code", 32'(err_code), 32'd2);
        step(); chk_out("badcs_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
`endif

        // 5A is junk, then zero length, then length 17 (> 16)
        push(8'h5A); push(8'hA5); push(8'h00); push(8'hA5); push(8'h11);
        step(); chk_out("badlen_drop", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_out("badlen_sof",  1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_out("badlen0_err", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("badlen0_code", 32'(err_code), 32'd1);
        step(); chk_out("badlen_sof2", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(); chk_out("badlen17_err", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("badlen17_code", 32'(err_code), 32'd1);
        step(); chk_out("badlen_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("badlen_fifo_drained", 32'(fifo.size()), 32'd0);

        // shortest frame: first byte is also the last
        push(8'hA5); push(8'h01); push(8'h42);
`ifdef UART_FRAME_CHECKSUM_EN
        push(8'hBD);
`endif
        step(); step();
`ifdef UART_FRAME_CHECKSUM_EN
        step(); chk_out("len1_b0", 1'b1, 1'b0, 1'b0, 8'h42, 1'b1);
        step(); chk_out("len1_done", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`else
        step(); chk_out("len1_b0", 1'b1, 1'b1, 1'b0, 8'h42, 1'b1);
`endif

        // longest legal frame: 16 bytes 00..0F, checksum 78
        push(8'hA5); push(8'h10);
        for (int i = 0; i < 16; i++) push(8'(i));
`ifdef UART_FRAME_CHECKSUM_EN
        push(8'h78);
`endif
        step(); step();
        for (int i = 0; i < 16; i++) begin
            step();
`ifdef UART_FRAME_CHECKSUM_EN
            chk_out("len16_byte", 1'b1, 1'b0, 1'b0, 8'(i), i == 15);
`else
            chk_out("len16_byte", 1'b1, i == 15, 1'b0, 8'(i), i == 15);
`endif
        end
`ifdef UART_FRAME_CHECKSUM_EN
        step(); chk_out("len16_done", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`endif
        step(); chk_out("len16_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // backpressure with a short timeout: stalled cycles must not count as idle
        timeout_value = 16'd2;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33);
`ifdef UART_FRAME_CHECKSUM_EN
        push(8'h97);
`endif
        step(); step();
        step(); chk_out("bp_b0", 1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        step(); chk_out("bp_b1", 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
        bus.m_ready = 1'b0;
        #1;
        chk("bp_rd_low", 32'(bus.rd_uart), 32'd0);
        step(); chk_out("bp_hold1", 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
        step(); chk_out("bp_hold2", 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
        chk("bp_fifo_kept", 32'(fifo.size()), `ifdef UART_FRAME_CHECKSUM_EN 32'd2 `else 32'd1 `endif);
        bus.m_ready = 1'b1;
        #1;
        chk("bp_rd_high", 32'(bus.rd_uart), 32'd1);
`ifdef UART_FRAME_CHECKSUM_EN
        step(); chk_out("bp_b2", 1'b1, 1'b0, 1'b0, 8'h33, 1'b1);
        step(); chk_out("bp_done", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`else
        step(); chk_out("bp_b2", 1'b1, 1'b1, 1'b0, 8'h33, 1'b1);
`endif
        step(); chk_out("bp_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // timeout 20: error rises on the 20th edge after the 11 pop
        timeout_value = 16'd20;
        push(8'hA5); push(8'h02); push(8'h11);
        step(); step();
        step(); chk_out("to_b0", 1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        first  = 0;
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (frame_err) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        chk("to_latency", 32'(first), 32'd20);
        chk("to_pulses", 32'(pulses), 32'd1);
        chk("to_code", 32'(err_code), 32'd3);

        // timeout disabled: the frame waits, then completes
        timeout_value = 16'd0;
        push(8'hA5); push(8'h02); push(8'h11);
        step(); step(); step();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_err) pulses++;
        end
        chk("to0_no_err", 32'(pulses), 32'd0);
        push(8'h22);
`ifdef UART_FRAME_CHECKSUM_EN
        push(8'hCB);
        step(); chk_out("to0_b1", 1'b1, 1'b0, 1'b0, 8'h22, 1'b1);
        step(); chk_out("to0_done", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`else
        step(); chk_out("to0_b1", 1'b1, 1'b1, 1'b0, 8'h22, 1'b1);
`endif
        step();

        // reset in the middle of the payload
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33);
        step(); step();
        step(); chk_out("rst_b0", 1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_rd_low", 32'(bus.rd_uart), 32'd0);
        step();
        chk_out("rst_outs", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_regs", {21'd0, bus.m_data, bus.m_last, err_code}, 32'd0);
        fifo.delete();
        drive_fifo();
        reset = 1'b0;
        good_frame("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
